dbg_csr_bank: RTL and testbench
===============================

DBG_CSR_BANK -- requirements
Module: dbg_csr_bank

Interface
REQ-001 SHALL have parameter NB_ADDR, default 7: SPI register address width.
REQ-002 SHALL have parameter NB_DATA, default 8: register data width.
REQ-003 SHALL have parameter N_MON, default 9, legal range 1..16: number of monitor probe channels.
REQ-004 SHALL have parameter N_FORCE, default 9, legal range 1..16: number of force control channels.
REQ-005 SHALL have parameter PULSE_LEN, default 4, legal range 1..255: sw_reset hold time in clk cycles.
REQ-006 SHALL have parameter ID_VALUE, default 8'hA2: constant returned at the ID address.
REQ-007 clk  input  1  system clock; all logic is on its rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 spi_addr  input  NB_ADDR  register address, synchronous to clk.
REQ-010 spi_wdata  input  NB_DATA  write data.
REQ-011 spi_wr_en  input  1  single-cycle write strobe.
REQ-012 spi_ss_n  input  1  SPI slave select, asynchronous to clk.
REQ-013 spi_rdata  output  NB_DATA  combinational read data.
REQ-014 status_in  input  NB_DATA  status probe, asynchronous.
REQ-015 mon_bus  input  N_MON*NB_DATA  monitor probes, channel i at bits [i*NB_DATA +: NB_DATA], asynchronous.
REQ-016 err_in  input  NB_DATA  error event bits, synchronous to clk, level or pulse.
REQ-017 sw_reset  output  NB_DATA  self-clearing reset control.
REQ-018 enable_sig  output  NB_DATA  enable control.
REQ-019 force_bus  output  N_FORCE*NB_DATA  force controls, channel i at bits [i*NB_DATA +: NB_DATA].
REQ-020 snap_cnt  output  NB_DATA  count of snapshots taken, wraps 2^NB_DATA-1 -> 0.

Function
REQ-021 Address map SHALL be: 0x00 status snapshot (RO), 0x01 err_sticky (W1C), 0x02 ID_VALUE (RO), 0x03 snap_cnt (RO), 0x10 sw_reset (RW), 0x11 enable_sig (RW), 0x20+i mon snapshot i (RO, i<N_MON), 0x30+i force i (RW, i<N_FORCE).
REQ-022 spi_ss_n SHALL pass through a 2-FF synchronizer; a synchronized 1->0 transition SHALL, one cycle later, load status_in and every mon_bus channel into the snapshot registers together and increment snap_cnt by 1.
REQ-023 Snapshot registers SHALL hold their values for the whole transaction, with no update while synchronized ss_n stays low.
REQ-024 err_sticky SHALL be updated each cycle as err_sticky <= (err_sticky & ~clr) | err_in, where clr = spi_wdata when spi_wr_en and addr==0x01, else 0; a simultaneous set and clear of one bit SHALL leave the bit set.
REQ-025 A write to 0x10 SHALL load sw_reset with spi_wdata and load the pulse counter with PULSE_LEN.
REQ-026 The pulse counter SHALL decrement each cycle while non-zero; on the cycle it reaches 0, sw_reset SHALL clear to 0, so sw_reset is held exactly PULSE_LEN cycles.
REQ-027 A rewrite of 0x10 during an active pulse SHALL reload both value and counter.
REQ-028 Writes to 0x11 and 0x30+i SHALL update the register on the next clk edge and hold it until the next write.
REQ-029 Writes to RO addresses, unmapped addresses, or channel indices >= N_MON / N_FORCE SHALL have no effect.
REQ-030 spi_rdata SHALL be a zero-latency combinational decode of spi_addr; unmapped or out-of-range addresses SHALL return 0.
REQ-031 RW registers SHALL read back their current value; sw_reset SHALL read back its live, possibly already-cleared, value.

Reset
REQ-032 While rst_n=0, SHALL hold all snapshots, err_sticky, snap_cnt, pulse counter, sw_reset, enable_sig and force_bus at 0.
REQ-033 While rst_n=0, SHALL hold both synchronizer stages at 1, so that release of reset with ss_n low does not produce a snapshot.
REQ-034 Reset assertion during an active pulse SHALL abort the pulse immediately.

Structure
REQ-035 A shared package dbg_csr_pkg SHALL hold the address constants: ADDR_STATUS, ADDR_ERR, ADDR_ID, ADDR_SNAPCNT, ADDR_SW_RESET, ADDR_ENABLE, ADDR_MON_BASE, ADDR_FORCE_BASE.
REQ-036 The only sub-module SHALL be sync_2ff, a parametrised-width 2-FF synchronizer with a reset value parameter, used for spi_ss_n.
REQ-037 Per-channel registers SHALL be built with generate loops over N_MON and N_FORCE.

Verification
REQ-038 mon ch3=0x5A; drive ss_n low; change ch3 to 0xFF; read 0x23 -> 0x5A; snap_cnt=1.
REQ-039 err_in bit2 pulsed one cycle; read 0x01 -> 0x04; write 0x04 to 0x01 in the same cycle as a new bit2 pulse -> bit stays 1; write 0x04 again with no pulse -> 0x00.
REQ-040 PULSE_LEN=4; write 0x10=0x81 -> sw_reset=0x81 for exactly 4 cycles, then 0x00; a rewrite at cycle 2 extends the pulse to 4 cycles from the rewrite.
REQ-041 N_FORCE=9; write 0x38=0x3C -> force ch8=0x3C; write 0x39=0x11 -> no change anywhere; read 0x39 -> 0x00; read 0x02 -> 0xA2.
REQ-042 Start 255 transactions, then one more -> snap_cnt wraps 0xFF -> 0x00.
REQ-043 Assert rst_n mid-pulse with ss_n low; release reset -> all outputs 0 and no snapshot taken.

Source files
------------

// File: rtl/dbg_csr_pkg.sv
// Shared address map for the debug CSR bank.
package dbg_csr_pkg;

  // Fixed single registers
  localparam int ADDR_STATUS     = 'h00;
  localparam int ADDR_ERR        = 'h01;
  localparam int ADDR_ID         = 'h02;
  localparam int ADDR_SNAPCNT    = 'h03;
  localparam int ADDR_SW_RESET   = 'h10;
  localparam int ADDR_ENABLE     = 'h11;

  // Per-channel pages: the low nibble of the address selects the channel
  localparam int ADDR_MON_BASE   = 'h20;
  localparam int ADDR_FORCE_BASE = 'h30;
  localparam int PAGE_SHIFT      = 4;

endpackage

// File: rtl/dbg_csr_bank_sync_2ff.sv
// Two-flop synchronizer with a configurable reset value.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back stages; both preset to RST_VAL while in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dbg_csr_bank.sv
// Debug CSR bank: snapshots of status/monitor probes taken at SPI
// transaction start, sticky error bits, a self-clearing reset pulse,
// an enable register and per-channel force registers.
//
// Write protocol: spi_wr_en is a single-cycle strobe; spi_addr and
// spi_wdata are sampled on the same rising clk edge where spi_wr_en=1.
// There is no backpressure. Reads are a pure combinational decode of
// spi_addr and are valid in the same cycle.
module dbg_csr_bank
  import dbg_csr_pkg::*;
#(
  parameter int                 NB_ADDR   = 7,
  parameter int                 NB_DATA   = 8,
  parameter int                 N_MON     = 9,
  parameter int                 N_FORCE   = 9,
  parameter int                 PULSE_LEN = 4,
  parameter logic [NB_DATA-1:0] ID_VALUE  = 8'hA2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NB_ADDR-1:0]         spi_addr,
  input  logic [NB_DATA-1:0]         spi_wdata,
  input  logic                       spi_wr_en,
  input  logic                       spi_ss_n,
  output logic [NB_DATA-1:0]         spi_rdata,
  input  logic [NB_DATA-1:0]         status_in,
  input  logic [N_MON*NB_DATA-1:0]   mon_bus,
  input  logic [NB_DATA-1:0]         err_in,
  output logic [NB_DATA-1:0]         sw_reset,
  output logic [NB_DATA-1:0]         enable_sig,
  output logic [N_FORCE*NB_DATA-1:0] force_bus,
  output logic [NB_DATA-1:0]         snap_cnt
);

  localparam int PG_W = NB_ADDR - PAGE_SHIFT;

  logic               ss_sync;
  logic               ss_prev;
  logic [1:0]         sync_vld;
  logic               snap_take;

  logic [NB_DATA-1:0] status_snap;
  logic [NB_DATA-1:0] mon_snap [N_MON];
  logic [NB_DATA-1:0] snap_q;
  logic [NB_DATA-1:0] err_sticky;
  logic [NB_DATA-1:0] err_clr;
  logic [NB_DATA-1:0] sw_q;
  logic [7:0]         pulse_cnt;
  logic [NB_DATA-1:0] enable_q;
  logic [NB_DATA-1:0] force_q [N_FORCE];

  logic [3:0]         ch_idx;
  logic [PG_W-1:0]    page;
  logic               mon_hit;
  logic               force_hit;
  logic               wr_err;
  logic               wr_sw;
  logic               wr_en_reg;

  // Address decode shared by the write and read paths
  assign ch_idx    = spi_addr[PAGE_SHIFT-1:0];
  assign page      = spi_addr[NB_ADDR-1:PAGE_SHIFT];
  assign mon_hit   = (page == PG_W'(ADDR_MON_BASE >> PAGE_SHIFT));
  assign force_hit = (page == PG_W'(ADDR_FORCE_BASE >> PAGE_SHIFT));
  assign wr_err    = spi_wr_en && (spi_addr == NB_ADDR'(ADDR_ERR));
  assign wr_sw     = spi_wr_en && (spi_addr == NB_ADDR'(ADDR_SW_RESET));
  assign wr_en_reg = spi_wr_en && (spi_addr == NB_ADDR'(ADDR_ENABLE));

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_ss_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (spi_ss_n),
    .q     (ss_sync)
  );

  // Falling-edge detector on synchronized ss_n. The synchronizer's reset
  // preset is not a real sample of ss_n, so the detector stays disarmed
  // until the second stage holds a genuine sample; a reset released with
  // ss_n already low therefore never looks like a transaction start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_vld <= 2'b00;
      ss_prev  <= 1'b0;
    end else begin
      sync_vld <= {sync_vld[0], 1'b1};
      ss_prev  <= ss_sync & sync_vld[1];
    end
  end

  assign snap_take = ss_prev & ~ss_sync;

  // Status snapshot and snapshot counter, loaded once per transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_snap <= '0;
      snap_q      <= '0;
    end else if (snap_take) begin
      status_snap <= status_in;
      snap_q      <= snap_q + 1'b1;
    end
  end

  // Monitor channel snapshots, captured together with the status snapshot
  for (genvar i = 0; i < N_MON; i++) begin : g_mon
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mon_snap[i] <= '0;
      end else if (snap_take) begin
        mon_snap[i] <= mon_bus[i*NB_DATA +: NB_DATA];
      end
    end
  end

  // Sticky error bits: a new event in the clearing cycle wins over the clear
  assign err_clr = wr_err ? spi_wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= '0;
    end else begin
      err_sticky <= (err_sticky & ~err_clr) | err_in;
    end
  end

  // Self-clearing reset pulse: value held for PULSE_LEN cycles, a rewrite restarts it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_q      <= '0;
      pulse_cnt <= '0;
    end else if (wr_sw) begin
      sw_q      <= spi_wdata;
      pulse_cnt <= 8'(PULSE_LEN);
    end else if (pulse_cnt != 8'd0) begin
      pulse_cnt <= pulse_cnt - 8'd1;
      if (pulse_cnt == 8'd1) begin
        sw_q <= '0;
      end
    end
  end

  // Enable register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q <= '0;
    end else if (wr_en_reg) begin
      enable_q <= spi_wdata;
    end
  end

  // Force channel registers; indices at or above N_FORCE match no channel
  for (genvar i = 0; i < N_FORCE; i++) begin : g_force
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        force_q[i] <= '0;
      end else if (spi_wr_en && force_hit && (ch_idx == 4'(i))) begin
        force_q[i] <= spi_wdata;
      end
    end
    assign force_bus[i*NB_DATA +: NB_DATA] = force_q[i];
  end

  // Combinational read decode; anything unmapped reads as zero
  always_comb begin
    spi_rdata = '0;
    case (spi_addr)
      NB_ADDR'(ADDR_STATUS):   spi_rdata = status_snap;
      NB_ADDR'(ADDR_ERR):      spi_rdata = err_sticky;
      NB_ADDR'(ADDR_ID):       spi_rdata = ID_VALUE;
      NB_ADDR'(ADDR_SNAPCNT):  spi_rdata = snap_q;
      NB_ADDR'(ADDR_SW_RESET): spi_rdata = sw_q;
      NB_ADDR'(ADDR_ENABLE):   spi_rdata = enable_q;
      default:                 spi_rdata = '0;
    endcase
    for (int i = 0; i < N_MON; i++) begin
      if (mon_hit && (ch_idx == 4'(i))) spi_rdata = mon_snap[i];
    end
    for (int i = 0; i < N_FORCE; i++) begin
      if (force_hit && (ch_idx == 4'(i))) spi_rdata = force_q[i];
    end
  end

  assign sw_reset   = sw_q;
  assign enable_sig = enable_q;
  assign snap_cnt   = snap_q;

endmodule

// File: tb/tb_dbg_csr_bank.sv
// Directed bench for dbg_csr_bank with a queue-based scoreboard.
module tb_dbg_csr_bank;

  localparam int NB_ADDR   = 7;
  localparam int NB_DATA   = 8;
  localparam int N_MON     = 9;
  localparam int N_FORCE   = 9;
  localparam int PULSE_LEN = 4;

  localparam int SEL_RDATA   = 0;
  localparam int SEL_SWRST   = 1;
  localparam int SEL_SNAPCNT = 2;
  localparam int SEL_ENABLE  = 3;
  localparam int SEL_FORCE8  = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NB_ADDR-1:0]         spi_addr  = '0;
  logic [NB_DATA-1:0]         spi_wdata = '0;
  logic                       spi_wr_en = 1'b0;
  logic                       spi_ss_n  = 1'b1;
  logic [NB_DATA-1:0]         spi_rdata;
  logic [NB_DATA-1:0]         status_in = '0;
  logic [N_MON*NB_DATA-1:0]   mon_bus   = '0;
  logic [NB_DATA-1:0]         err_in    = '0;
  logic [NB_DATA-1:0]         sw_reset;
  logic [NB_DATA-1:0]         enable_sig;
  logic [N_FORCE*NB_DATA-1:0] force_bus;
  logic [NB_DATA-1:0]         snap_cnt;

  dbg_csr_bank #(
    .NB_ADDR   (NB_ADDR),
    .NB_DATA   (NB_DATA),
    .N_MON     (N_MON),
    .N_FORCE   (N_FORCE),
    .PULSE_LEN (PULSE_LEN),
    .ID_VALUE  (8'hA2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_addr   (spi_addr),
    .spi_wdata  (spi_wdata),
    .spi_wr_en  (spi_wr_en),
    .spi_ss_n   (spi_ss_n),
    .spi_rdata  (spi_rdata),
    .status_in  (status_in),
    .mon_bus    (mon_bus),
    .err_in     (err_in),
    .sw_reset   (sw_reset),
    .enable_sig (enable_sig),
    .force_bus  (force_bus),
    .snap_cnt   (snap_cnt)
  );

  // ---------------- scoreboard ----------------
  logic [NB_DATA-1:0] exp_q[$];
  int                 sel_q[$];
  string              tag_q[$];
  int                 n_vec  = 0;
  int                 n_miss = 0;

  logic [NB_DATA-1:0] mon_exp;
  logic [NB_DATA-1:0] mon_act;
  int                 mon_sel;
  string              mon_tag;

  // Monitor: on every falling edge, check all expectations queued this cycle
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_sel = sel_q.pop_front();
      mon_tag = tag_q.pop_front();
      case (mon_sel)
        SEL_SWRST:   mon_act = sw_reset;
        SEL_SNAPCNT: mon_act = snap_cnt;
        SEL_ENABLE:  mon_act = enable_sig;
        SEL_FORCE8:  mon_act = force_bus[8*NB_DATA +: NB_DATA];
        default:     mon_act = spi_rdata;
      endcase
      n_vec++;
      if (mon_act !== mon_exp) begin
        n_miss++;
        $display("FAIL %s: got %02h expected %02h", mon_tag, mon_act, mon_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input int sel, input logic [NB_DATA-1:0] exp, input string tag);
    sel_q.push_back(sel);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic expect_rd(input logic [NB_ADDR-1:0] addr, input logic [NB_DATA-1:0] exp,
                           input string tag);
    spi_addr = addr;
    expect_out(SEL_RDATA, exp, tag);
    tick();
  endtask

  task automatic wr(input logic [NB_ADDR-1:0] addr, input logic [NB_DATA-1:0] data);
    spi_addr  = addr;
    spi_wdata = data;
    spi_wr_en = 1'b1;
    tick();
    spi_wr_en = 1'b0;
  endtask

  task automatic set_mon(input int ch, input logic [NB_DATA-1:0] val);
    mon_bus[ch*NB_DATA +: NB_DATA] = val;
  endtask

  task automatic xact();
    spi_ss_n = 1'b0;
    repeat (4) tick();
    spi_ss_n = 1'b1;
    repeat (4) tick();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    n_miss++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    repeat (2) tick();
    expect_out(SEL_SWRST, 8'h00, "rst_sw_reset");
    expect_out(SEL_SNAPCNT, 8'h00, "rst_snap_cnt");
    expect_out(SEL_ENABLE, 8'h00, "rst_enable");
    expect_out(SEL_FORCE8, 8'h00, "rst_force8");
    expect_rd(7'h00, 8'h00, "rst_status");
    expect_rd(7'h01, 8'h00, "rst_err");
    rst_n = 1'b1;
    repeat (4) tick();

    // Constant and unmapped reads
    expect_rd(7'h02, 8'hA2, "id");
    expect_rd(7'h39, 8'h00, "force_oob_rd");
    expect_rd(7'h29, 8'h00, "mon_oob_rd");
    expect_rd(7'h7F, 8'h00, "unmapped_rd");

    // Snapshot on transaction start, held while ss_n stays low
    status_in = 8'h3C;
    for (int ch = 0; ch < N_MON; ch++) set_mon(ch, 8'(8'h10 + ch));
    set_mon(3, 8'h5A);
    tick();
    spi_ss_n = 1'b0;
    tick();
    tick();
    expect_out(SEL_SNAPCNT, 8'h00, "snap_latency");
    tick();
    expect_out(SEL_SNAPCNT, 8'h01, "snap_cnt_1");
    set_mon(3, 8'hFF);
    status_in = 8'h00;
    tick();
    tick();
    expect_rd(7'h23, 8'h5A, "mon3_snap");
    expect_rd(7'h00, 8'h3C, "status_snap");
    expect_rd(7'h20, 8'h10, "mon0_snap");
    expect_rd(7'h28, 8'h18, "mon8_snap");
    expect_rd(7'h03, 8'h01, "snapcnt_rd");
    spi_ss_n = 1'b1;
    repeat (4) tick();
    expect_rd(7'h23, 8'h5A, "snap_no_update_on_rise");

    // Sticky errors
    err_in = 8'h04;
    tick();
    err_in = 8'h00;
    expect_rd(7'h01, 8'h04, "err_set");
    spi_addr  = 7'h01;
    spi_wdata = 8'h04;
    spi_wr_en = 1'b1;
    err_in    = 8'h04;
    tick();
    spi_wr_en = 1'b0;
    err_in    = 8'h00;
    expect_rd(7'h01, 8'h04, "err_set_beats_clr");
    wr(7'h01, 8'h04);
    expect_rd(7'h01, 8'h00, "err_clr");
    err_in = 8'h81;
    tick();
    err_in = 8'h00;
    wr(7'h01, 8'h01);
    expect_rd(7'h01, 8'h80, "err_partial_clr");
    wr(7'h01, 8'h80);

    // Force / enable registers and ignored writes
    wr(7'h38, 8'h3C);
    expect_out(SEL_FORCE8, 8'h3C, "force8_out");
    expect_rd(7'h38, 8'h3C, "force8_rd");
    wr(7'h39, 8'h11);
    expect_rd(7'h39, 8'h00, "force_oob_wr");
    for (int a = 0; a < 8; a++) begin
      expect_rd(7'(7'h30 + a), 8'h00, $sformatf("force%0d_untouched", a));
    end
    expect_out(SEL_FORCE8, 8'h3C, "force8_after_oob");
    expect_rd(7'h02, 8'hA2, "id_again");
    wr(7'h11, 8'hA5);
    expect_out(SEL_ENABLE, 8'hA5, "enable_out");
    expect_rd(7'h11, 8'hA5, "enable_rd");
    wr(7'h31, 8'h42);
    expect_rd(7'h31, 8'h42, "force1_rd");
    expect_out(SEL_FORCE8, 8'h3C, "force8_after_ch1");
    wr(7'h03, 8'h55);
    expect_rd(7'h03, 8'h01, "ro_snapcnt_wr");
    wr(7'h23, 8'h77);
    expect_rd(7'h23, 8'h5A, "ro_mon_wr");
    wr(7'h7F, 8'hFF);
    expect_out(SEL_ENABLE, 8'hA5, "enable_after_unmapped_wr");
    expect_rd(7'h7F, 8'h00, "unmapped_wr");

    // Reset pulse: exactly PULSE_LEN cycles
    wr(7'h10, 8'h81);
    for (int k = 0; k < PULSE_LEN; k++) begin
      expect_out(SEL_SWRST, 8'h81, $sformatf("pulse_c%0d", k));
      tick();
    end
    expect_out(SEL_SWRST, 8'h00, "pulse_end");
    expect_rd(7'h10, 8'h00, "sw_reset_rd_cleared");

    // Rewrite at cycle 2 restarts the pulse
    wr(7'h10, 8'h81);
    expect_out(SEL_SWRST, 8'h81, "rw_c0");
    tick();
    expect_out(SEL_SWRST, 8'h81, "rw_c1");
    wr(7'h10, 8'h42);
    for (int k = 0; k < PULSE_LEN; k++) begin
      expect_out(SEL_SWRST, 8'h42, $sformatf("rw_pulse_c%0d", k));
      tick();
    end
    expect_out(SEL_SWRST, 8'h00, "rw_pulse_end");
    tick();

    // snap_cnt wrap
    repeat (254) xact();
    expect_out(SEL_SNAPCNT, 8'hFF, "snap_cnt_ff");
    tick();
    xact();
    expect_out(SEL_SNAPCNT, 8'h00, "snap_cnt_wrap");
    expect_rd(7'h03, 8'h00, "snapcnt_rd_wrap");

    // Reset mid-pulse with ss_n low
    err_in = 8'h10;
    tick();
    err_in = 8'h00;
    wr(7'h10, 8'h81);
    tick();
    spi_ss_n = 1'b0;
    tick();
    rst_n = 1'b0;
    expect_out(SEL_SWRST, 8'h00, "rst_abort_pulse");
    expect_out(SEL_SNAPCNT, 8'h00, "rst_mid_snapcnt");
    expect_out(SEL_ENABLE, 8'h00, "rst_mid_enable");
    expect_out(SEL_FORCE8, 8'h00, "rst_mid_force8");
    expect_rd(7'h23, 8'h00, "rst_mid_mon3");
    status_in = 8'h99;
    set_mon(3, 8'h66);
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    expect_out(SEL_SNAPCNT, 8'h00, "no_snap_after_rst");
    expect_out(SEL_SWRST, 8'h00, "post_rst_sw_reset");
    expect_out(SEL_ENABLE, 8'h00, "post_rst_enable");
    expect_out(SEL_FORCE8, 8'h00, "post_rst_force8");
    expect_rd(7'h00, 8'h00, "post_rst_status");
    expect_rd(7'h23, 8'h00, "post_rst_mon3");
    expect_rd(7'h01, 8'h00, "post_rst_err");
    expect_rd(7'h31, 8'h00, "post_rst_force1");

    // Normal transaction after reset
    spi_ss_n = 1'b1;
    repeat (4) tick();
    xact();
    expect_out(SEL_SNAPCNT, 8'h01, "post_rst_snap_cnt");
    expect_rd(7'h00, 8'h99, "post_rst_status_snap");
    expect_rd(7'h23, 8'h66, "post_rst_mon3_snap");

    // Drain and report
    repeat (2) tick();
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
